// File: rtl/sccb_cfg_sequencer_pkg.sv
// Shared types and constants for the OV7670 SCCB configuration sequencer.
// Table entries are {reg, data}; END_MARK ends a table, {DELAY_TAG, nn} waits nn ms.
package sccb_cfg_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_WR,
        S_DELAY,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG  = 8'hF0;

    localparam logic [7:0]  REG_CLKRC  = 8'h11;
    localparam logic [7:0]  REG_COM7   = 8'h12;
    localparam logic [7:0]  REG_TSLB   = 8'h3A;
    localparam logic [7:0]  REG_COM15  = 8'h40;
    localparam logic [7:0]  REG_RGB444 = 8'h8C;

    localparam logic [7:0]  COM7_RESET = 8'h80;

    function automatic logic [15:0] cfg_entry(input logic [7:0] reg_a, input logic [7:0] data);
        return {reg_a, data};
    endfunction

endpackage

// File: rtl/sccb_cfg_sequencer_if.sv
// Write-request bus between the configuration sequencer and the SCCB bit engine.
interface sccb_cfg_sequencer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;
    logic       wr_done;
    logic       wr_nack;

    modport master (
        output wr_valid, wr_reg, wr_data,
        input  wr_ready, wr_done, wr_nack
    );

    modport slave (
        input  wr_valid, wr_reg, wr_data,
        output wr_ready, wr_done, wr_nack
    );
endinterface

// File: rtl/sccb_cfg_sequencer_rom.sv
// Default OV7670 bring-up table: soft reset, 10 ms settle, then clock/format setup.
// Synchronous read, one cycle latency; unused entries read as END_MARK.
module sccb_cfg_sequencer_rom
    import sccb_cfg_sequencer_pkg::*;
#(
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    output logic [15:0]   data_o
);

    always_ff @(posedge clk) begin
        case (32'(addr_i))
            32'd0:   data_o <= cfg_entry(REG_COM7, COM7_RESET);
            32'd1:   data_o <= cfg_entry(DELAY_TAG, 8'h0A);
            32'd2:   data_o <= cfg_entry(REG_CLKRC, 8'h01);
            32'd3:   data_o <= cfg_entry(REG_COM7, 8'h04);
            32'd4:   data_o <= cfg_entry(REG_COM15, 8'hD0);
            32'd5:   data_o <= cfg_entry(REG_TSLB, 8'h04);
            32'd6:   data_o <= cfg_entry(REG_RGB444, 8'h00);
            default: data_o <= END_MARK;
        endcase
    end

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks the register table and issues one SCCB write per entry, with ms delays,
// NACK retries and done/error reporting.
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_FETCH   | rom_addr presented, ROM read in flight
//   S_DECODE  | rom_data valid: end mark, delay or write
//   S_ISSUE   | wr_valid held until wr_ready
//   S_WAIT_WR | waiting for wr_done / wr_nack
//   S_DELAY   | down-counting the ms delay
//   S_DONE    | table completed, done held
//   S_ERROR   | retries exhausted, err held
module sccb_cfg_sequencer
    import sccb_cfg_sequencer_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned ROM_AW    = 6,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic [ROM_AW-1:0]     rom_addr_o,
    input  logic [15:0]           rom_data_i,
    sccb_cfg_sequencer_if.master  wr,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ROM_AW-1:0]     err_idx_o
);

    localparam logic [31:0]       MS_CYC    = 32'(CLK_HZ / 1000);
    localparam logic [ROM_AW-1:0] LAST_IDX  = '1;
    localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRY);

    if (64'(MS_CYC) * 64'd255 > 64'h0000_0000_FFFF_FFFF) begin : g_dly_chk
        $error("255 ms at CLK_HZ does not fit the 32-bit delay counter");
    end
    if (MAX_RETRY > 255) begin : g_retry_chk
        $error("MAX_RETRY must fit in 8 bits");
    end

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] idx_q, idx_d;
    logic [ROM_AW-1:0] err_idx_q, err_idx_d;
    logic [7:0]        retry_q, retry_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        data_q, data_d;
    logic [31:0]       dly_q, dly_d;
    logic [31:0]       dly_total;
    logic              valid_q;
    logic              adv;

    assign dly_total = 32'(rom_data_i[7:0]) * MS_CYC;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        retry_d   = retry_q;
        reg_d     = reg_q;
        data_d    = data_q;
        dly_d     = dly_q;
        adv       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data_i == END_MARK) begin
                    state_d = S_DONE;
                end else if (rom_data_i[15:8] == DELAY_TAG) begin
                    if (dly_total == 32'd0) begin
                        adv = 1'b1;
                    end else begin
                        dly_d   = dly_total - 32'd1;
                        state_d = S_DELAY;
                    end
                end else begin
                    reg_d   = rom_data_i[15:8];
                    data_d  = rom_data_i[7:0];
                    retry_d = 8'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (valid_q && wr.wr_ready) state_d = S_WAIT_WR;
            end
            S_WAIT_WR: begin
                if (wr.wr_done) begin
                    if (!wr.wr_nack) begin
                        adv = 1'b1;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        state_d = S_ISSUE;
                    end else begin
                        err_idx_d = idx_q;
                        state_d   = S_ERROR;
                    end
                end
            end
            S_DELAY: begin
                if (dly_q == 32'd0) adv = 1'b1;
                else                dly_d = dly_q - 32'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // A table without END_MARK stops after its last slot instead of wrapping.
        if (adv) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + ROM_AW'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_idx_q <= '0;
            retry_q   <= 8'd0;
            reg_q     <= 8'd0;
            data_q    <= 8'd0;
            dly_q     <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            retry_q   <= retry_d;
            reg_q     <= reg_d;
            data_q    <= data_d;
            dly_q     <= dly_d;
            valid_q   <= (state_d == S_ISSUE);
        end
    end

    assign wr.wr_valid = valid_q;
    assign wr.wr_reg   = reg_q;
    assign wr.wr_data  = data_q;
    assign rom_addr_o  = idx_q;
    assign busy_o      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERROR);
    assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Directed bench for sccb_cfg_sequencer: table ROM model plus a small SCCB engine
// model with configurable ready stall and per-register NACK injection.
module tb_sccb_cfg_sequencer;

    localparam int unsigned CLK_HZ = 10000;   // 1 ms = 10 cycles

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data = 16'hFFFF;
    logic        busy, done, err;
    logic [5:0]  err_idx;
    logic [5:0]  rom_chk_addr = 6'd0;
    logic [15:0] rom_chk_data;

    always #5 clk = ~clk;

    sccb_cfg_sequencer_if bus();

    sccb_cfg_sequencer #(.CLK_HZ(CLK_HZ), .ROM_AW(6), .MAX_RETRY(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .wr         (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_idx_o  (err_idx)
    );

    sccb_cfg_sequencer_rom #(.AW(6)) u_rom (
        .clk    (clk),
        .addr_i (rom_chk_addr),
        .data_o (rom_chk_data)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_edge = 0;

    logic [15:0] tbl [64];
    always @(posedge clk) rom_data <= tbl[rom_addr];
    always @(posedge clk) cyc <= cyc + 1;

    // engine configuration (written by the test process only)
    int         stall_cfg = 0;
    logic [7:0] nack_reg = 8'h00;
    bit         nack_always = 1'b0;
    int         nack_until = 0;

    // engine state and logs (written by the engine process only)
    int         log_cnt = 0;
    logic [7:0] log_reg [256];
    logic [7:0] log_data [256];
    int         vrise [256];
    int         vrise_n = 0;
    int         done_edge [256];
    int         done_n = 0;
    int         pend = 0;
    bit         pend_nack = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] cap_reg = 8'h00, cap_data = 8'h00;
    int         stall_left = 0;
    int         stall_obs = 0;
    int         stable_bad = 0;
    int         nack_given = 0;

    initial begin
        bus.wr_ready = 1'b0;
        bus.wr_done  = 1'b0;
        bus.wr_nack  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.wr_ready = 1'b0;
                bus.wr_done  = 1'b0;
                bus.wr_nack  = 1'b0;
                pend         = 0;
                prev_valid   = 1'b0;
            end else begin
                bus.wr_done = 1'b0;
                bus.wr_nack = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.wr_done = 1'b1;
                        bus.wr_nack = pend_nack;
                        done_edge[done_n] = cyc + 1;
                        done_n++;
                    end
                end
                if (bus.wr_ready) begin
                    log_reg[log_cnt]  = cap_reg;
                    log_data[log_cnt] = cap_data;
                    log_cnt++;
                    pend_nack = (cap_reg == nack_reg) && (nack_always || nack_given < nack_until);
                    if (pend_nack) nack_given++;
                    pend = 2;
                    bus.wr_ready = 1'b0;
                end else if (bus.wr_valid) begin
                    if (!prev_valid) begin
                        vrise[vrise_n] = cyc + 1;
                        vrise_n++;
                        cap_reg    = bus.wr_reg;
                        cap_data   = bus.wr_data;
                        stall_left = stall_cfg;
                    end else if (bus.wr_reg !== cap_reg || bus.wr_data !== cap_data) begin
                        stable_bad++;
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                        stall_obs++;
                    end else begin
                        bus.wr_ready = 1'b1;
                    end
                end
                prev_valid = bus.wr_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic set_tbl4(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        for (int i = 0; i < 64; i++) tbl[i] = 16'hFFFF;
        tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
    endtask

    // start is sampled at edge start_edge; returns on the negedge after it
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit to);
        to = 1'b1;
        for (int i = 0; i < max; i++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        set_tbl4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy/done/err=%b want 000", {busy, done, err}); end
        checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.wr_valid); end
        checks++; if ({rom_addr, err_idx} !== 12'd0) begin errors++; $display("FAIL reset_idx: got addr=%0d err_idx=%0d want 0/0", rom_addr, err_idx); end
        checks++; if ({bus.wr_reg, bus.wr_data} !== 16'h0000) begin errors++; $display("FAIL reset_regdata: got %h want 0000", {bus.wr_reg, bus.wr_data}); end
        rst_n = 1'b1;
        rom_chk_addr = 6'd0;
        @(posedge clk); #1;
        checks++; if (rom_chk_data !== 16'h1280) begin errors++; $display("FAIL rom_entry0: got %h want 1280", rom_chk_data); end
        rom_chk_addr = 6'd1;
        @(posedge clk); #1;
        checks++; if (rom_chk_data !== 16'hF00A) begin errors++; $display("FAIL rom_entry1: got %h want f00a", rom_chk_data); end
        rom_chk_addr = 6'd63;
        @(posedge clk); #1;
        checks++; if (rom_chk_data !== 16'hFFFF) begin errors++; $display("FAIL rom_entry63: got %h want ffff", rom_chk_data); end
    endtask

    task automatic test_basic();
        int b, vb;
        bit to;
        b = log_cnt; vb = vrise_n;
        set_tbl4(16'h1280, 16'h8C02, 16'hFFFF, 16'hFFFF);
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_idle(300, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: busy still %b", busy); end
        checks++; if (log_cnt - b !== 2) begin errors++; $display("FAIL basic_count: got %0d want 2", log_cnt - b); end
        checks++; if ({log_reg[b], log_data[b]} !== 16'h1280) begin errors++; $display("FAIL basic_wr0: got %h%h want 1280", log_reg[b], log_data[b]); end
        checks++; if ({log_reg[b+1], log_data[b+1]} !== 16'h8C02) begin errors++; $display("FAIL basic_wr1: got %h%h want 8c02", log_reg[b+1], log_data[b+1]); end
        checks++; if ({done, busy, err} !== 3'b100) begin errors++; $display("FAIL basic_flags: got done/busy/err=%b want 100", {done, busy, err}); end
        checks++; if (vrise[vb] !== start_edge + 3) begin errors++; $display("FAIL basic_latency: wr_valid first seen at edge %0d want %0d", vrise[vb], start_edge + 3); end
    endtask

    task automatic test_delay();
        int b, vb, db;
        bit to;
        b = log_cnt; vb = vrise_n; db = done_n;
        set_tbl4(16'h1280, 16'hF005, 16'h4010, 16'hFFFF);
        pulse_start();
        wait_idle(500, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL delay_timeout: busy still %b", busy); end
        checks++; if (log_cnt - b !== 2 || log_reg[b+1] !== 8'h40) begin errors++; $display("FAIL delay_writes: got count=%0d reg1=%h want 2/40", log_cnt - b, log_reg[b+1]); end
        // done sampled at edge D: FETCH, DECODE, 50 DELAY edges, FETCH, DECODE->ISSUE, seen at D+55
        checks++; if (vrise[vb+1] - done_edge[db] !== 55) begin errors++; $display("FAIL delay_gap: got %0d edges want 55", vrise[vb+1] - done_edge[db]); end
    endtask

    task automatic test_retry();
        int b;
        bit to;
        b = log_cnt;
        nack_reg = 8'h8C; nack_always = 1'b0; nack_until = nack_given + 2;
        set_tbl4(16'h1280, 16'h8C02, 16'hFFFF, 16'hFFFF);
        pulse_start();
        wait_idle(400, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL retry_timeout: busy still %b", busy); end
        checks++; if (log_cnt - b !== 4) begin errors++; $display("FAIL retry_count: got %0d want 4", log_cnt - b); end
        checks++; if ({log_reg[b+1], log_reg[b+2], log_reg[b+3]} !== 24'h8C8C8C) begin errors++; $display("FAIL retry_regs: got %h %h %h want 8c 8c 8c", log_reg[b+1], log_reg[b+2], log_reg[b+3]); end
        checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL retry_flags: got done/err=%b want 10", {done, err}); end
    endtask

    task automatic test_error();
        int b, vb;
        bit to;
        b = log_cnt;
        nack_reg = 8'h40; nack_always = 1'b1;
        set_tbl4(16'h1280, 16'h8C02, 16'h4010, 16'hFFFF);
        pulse_start();
        wait_idle(500, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL error_timeout: busy still %b", busy); end
        checks++; if (log_cnt - b !== 6) begin errors++; $display("FAIL error_count: got %0d want 6", log_cnt - b); end
        checks++; if ({err, done, busy} !== 3'b100 || err_idx !== 6'd2) begin errors++; $display("FAIL error_flags: got err/done/busy=%b idx=%0d want 100 idx=2", {err, done, busy}, err_idx); end
        vb = vrise_n;
        repeat (20) @(negedge clk);
        checks++; if (vrise_n !== vb || bus.wr_valid !== 1'b0) begin errors++; $display("FAIL error_quiet: got %0d new requests valid=%b want 0", vrise_n - vb, bus.wr_valid); end
        nack_always = 1'b0;
        b = log_cnt;
        pulse_start();
        checks++; if ({err, busy} !== 2'b01) begin errors++; $display("FAIL error_restart: got err/busy=%b want 01", {err, busy}); end
        wait_idle(500, to);
        checks++; if (to !== 1'b0 || log_cnt - b !== 3 || log_reg[b] !== 8'h12 || done !== 1'b1) begin errors++; $display("FAIL error_rerun: got to=%b count=%0d reg0=%h done=%b want 0/3/12/1", to, log_cnt - b, log_reg[b], done); end
    endtask

    task automatic test_stall();
        int b, so, sb;
        bit to;
        b = log_cnt; so = stall_obs; sb = stable_bad;
        stall_cfg = 7;
        set_tbl4(16'h4010, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        pulse_start();
        wait_idle(300, to);
        stall_cfg = 0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: busy still %b", busy); end
        checks++; if (stall_obs - so !== 7) begin errors++; $display("FAIL stall_held: valid held %0d stalled cycles want 7", stall_obs - so); end
        checks++; if (stable_bad - sb !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes of reg/data want 0", stable_bad - sb); end
        checks++; if (log_cnt - b !== 1 || {log_reg[b], log_data[b]} !== 16'h4010) begin errors++; $display("FAIL stall_single: got count=%0d wr=%h%h want 1/4010", log_cnt - b, log_reg[b], log_data[b]); end
    endtask

    task automatic test_reset_mid();
        int b;
        bit to;
        b = log_cnt;
        set_tbl4(16'h1280, 16'h8C02, 16'hFFFF, 16'hFFFF);
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (log_cnt - b == 2) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstmid_reach: entry 1 accepts=%0d want 2", log_cnt - b); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.wr_valid, busy, done, err} !== 4'b0000 || rom_addr !== 6'd0 || {bus.wr_reg, bus.wr_data} !== 16'h0000) begin
            errors++; $display("FAIL rstmid_outputs: got valid/busy/done/err=%b addr=%0d wr=%h want 0000/0/0000", {bus.wr_valid, busy, done, err}, rom_addr, {bus.wr_reg, bus.wr_data});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b = log_cnt;
        pulse_start();
        checks++; if (rom_addr !== 6'd0 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_restart: got addr=%0d busy=%b want 0/1", rom_addr, busy); end
        wait_idle(300, to);
        checks++; if (to !== 1'b0 || log_cnt - b !== 2 || log_reg[b] !== 8'h12 || done !== 1'b1) begin errors++; $display("FAIL rstmid_rerun: got to=%b count=%0d reg0=%h done=%b want 0/2/12/1", to, log_cnt - b, log_reg[b], done); end
    endtask

    task automatic test_no_end();
        int b;
        bit to;
        b = log_cnt;
        for (int i = 0; i < 64; i++) tbl[i] = {8'(i), ~8'(i)};
        pulse_start();
        wait_idle(2000, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL noend_timeout: busy still %b", busy); end
        checks++; if (log_cnt - b !== 64) begin errors++; $display("FAIL noend_count: got %0d want 64", log_cnt - b); end
        checks++; if ({log_reg[b+63], log_data[b+63]} !== 16'h3FC0) begin errors++; $display("FAIL noend_last: got %h%h want 3fc0", log_reg[b+63], log_data[b+63]); end
        checks++; if ({done, err, busy} !== 3'b100) begin errors++; $display("FAIL noend_flags: got done/err/busy=%b want 100", {done, err, busy}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_delay();
        test_retry();
        test_error();
        test_stall();
        test_reset_mid();
        test_no_end();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
